// File: rtl/button_pulse_gen.sv
// Push-button front end: synchronises a raw bouncing button level and
// debounces it in both directions. Each accepted press produces one
// single-cycle trigger pulse for the lamp timer, plus a status level,
// a busy flag and a wrapping press counter.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500,  // stable samples to accept a press or a release, >= 2
    parameter int CNT_W           = 8     // press_count width
) (
    input  logic             clk,
    input  logic             rstn,        // synchronous, active-high reset
    input  logic             btn_in,      // raw level, asynchronous to clk
    output logic             pulse,
    output logic             level,
    output logic             busy,
    output logic [CNT_W-1:0] press_count
);

    localparam int            DW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    logic             s1;
    logic             btn_sync;
    state_t           state, state_nx;
    logic [DW-1:0]    dcnt, dcnt_nx;
    logic             pulse_nx;
    logic             level_nx;
    logic [CNT_W-1:0] count_nx;

    // Two-flop synchroniser; btn_sync is the only view of the button the FSM has.
    always_ff @(posedge clk) begin
        if (rstn) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn_in;
            btn_sync <= s1;
        end
    end

    // Debounce FSM next state, counter and registered-output next values.
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        pulse_nx = 1'b0;
        level_nx = level;
        count_nx = press_count;
        unique case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nx = PRESS_DB;
                    dcnt_nx  = '0;
                end
            end
            PRESS_DB: begin
                // Any low sample throws away partial qualification.
                if (!btn_sync) begin
                    state_nx = IDLE;
                end else if (dcnt == DLAST) begin
                    state_nx = HELD;
                    pulse_nx = 1'b1;
                    level_nx = 1'b1;
                    count_nx = press_count + 1'b1;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_nx = REL_DB;
                    dcnt_nx  = '0;
                end
            end
            REL_DB: begin
                // A high sample here is release bounce: back to HELD without a new pulse.
                if (btn_sync) begin
                    state_nx = HELD;
                end else if (dcnt == DLAST) begin
                    state_nx = IDLE;
                    level_nx = 1'b0;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counter and output registers; busy tracks the state being entered.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state       <= IDLE;
            dcnt        <= '0;
            pulse       <= 1'b0;
            level       <= 1'b0;
            busy        <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nx;
            dcnt        <= dcnt_nx;
            pulse       <= pulse_nx;
            level       <= level_nx;
            busy        <= (state_nx != IDLE);
            press_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen with DEBOUNCE_CYCLES=4. Expected pulses
// (cycle stamp and press count) are queued when a press is driven; a
// monitor queues observed pulses, and each scenario pairs them up.
module tb_button_pulse_gen;

    localparam int D = 4;
    localparam int LAT = D + 3;  // negedge stamp of pulse relative to the drive negedge

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_in;
    logic       pulse, level, busy;
    logic [7:0] press_count;

    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_cnt = 8'd0;
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    button_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .btn_in(btn_in),
        .pulse(pulse), .level(level), .busy(busy), .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which pulse is high.
    always @(negedge clk) begin
        if (pulse === 1'b1) begin
            ev_t o;
            o.cyc = cyc;
            o.cnt = press_count;
            obs_q.push_back(o);
        end
    end

    function automatic ev_t mk(input int c, input logic [7:0] n);
        ev_t e;
        e.cyc = c;
        e.cnt = n;
        return e;
    endfunction

    task automatic test_reset();
        int k;
        btn_in = 1'b1;
        rstn   = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (pulse !== 1'b0) begin mismatched++; $display("FAIL rst_pulse: got %b expected 0", pulse); end
        compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL rst_level: got %b expected 0", level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b expected 0", busy); end
        compared++; if (press_count !== 8'd0) begin mismatched++; $display("FAIL rst_count: got %0d expected 0", press_count); end
        rstn = 1'b0;
        k = cyc;
        exp_cnt = 8'd1;
        exp_q.push_back(mk(k + LAT, exp_cnt));
        repeat (12) @(negedge clk);
        compared++; if (level !== 1'b1) begin mismatched++; $display("FAIL rst_held_level: got %b expected 1", level); end
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        compared++; if (exp_q.size() != obs_q.size()) begin mismatched++; $display("FAIL rst_npulse: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            compared++; if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin mismatched++; $display("FAIL rst_pulse_ev: got cyc %0d cnt %0d expected cyc %0d cnt %0d", o.cyc, o.cnt, e.cyc, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clean_press();
        int k;
        @(negedge clk);
        btn_in = 1'b1;
        k = cyc;
        exp_cnt++;
        exp_q.push_back(mk(k + LAT, exp_cnt));
        repeat (20) @(negedge clk);
        compared++; if (level !== 1'b1) begin mismatched++; $display("FAIL clean_level: got %b expected 1", level); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL clean_busy: got %b expected 1", busy); end
        compared++; if (press_count !== exp_cnt) begin mismatched++; $display("FAIL clean_count: got %0d expected %0d", press_count, exp_cnt); end
        btn_in = 1'b0;
        repeat (D + 2) @(negedge clk);
        compared++; if (level !== 1'b1) begin mismatched++; $display("FAIL clean_level_before_fall: got %b expected 1", level); end
        @(negedge clk);
        compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL clean_level_fall: got %b expected 0", level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL clean_busy_fall: got %b expected 0", busy); end
        compared++; if (exp_q.size() != obs_q.size()) begin mismatched++; $display("FAIL clean_npulse: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            compared++; if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin mismatched++; $display("FAIL clean_pulse_ev: got cyc %0d cnt %0d expected cyc %0d cnt %0d", o.cyc, o.cnt, e.cyc, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_press_bounce();
        int k;
        @(negedge clk);
        btn_in = 1'b1;
        k = cyc;
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        @(negedge clk);
        btn_in = 1'b1;
        exp_cnt++;
        exp_q.push_back(mk(k + 4 + LAT, exp_cnt));
        repeat (20) @(negedge clk);
        compared++; if (press_count !== exp_cnt) begin mismatched++; $display("FAIL bounce_count: got %0d expected %0d", press_count, exp_cnt); end
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        compared++; if (exp_q.size() != obs_q.size()) begin mismatched++; $display("FAIL bounce_npulse: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            compared++; if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin mismatched++; $display("FAIL bounce_pulse_ev: got cyc %0d cnt %0d expected cyc %0d cnt %0d", o.cyc, o.cnt, e.cyc, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_release_bounce();
        int k;
        @(negedge clk);
        btn_in = 1'b1;
        k = cyc;
        exp_cnt++;
        exp_q.push_back(mk(k + LAT, exp_cnt));
        repeat (12) @(negedge clk);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        @(negedge clk);
        btn_in = 1'b0;
        // Steady release driven three cycles after the first fall: level holds until the
        // debounce after the glitch completes.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++; if (level !== 1'b1) begin mismatched++; $display("FAIL relb_level_hold%0d: got %b expected 1", i, level); end
        end
        @(negedge clk);
        compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL relb_level_fall: got %b expected 0", level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL relb_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
        compared++; if (exp_q.size() != obs_q.size()) begin mismatched++; $display("FAIL relb_npulse: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            compared++; if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin mismatched++; $display("FAIL relb_pulse_ev: got cyc %0d cnt %0d expected cyc %0d cnt %0d", o.cyc, o.cnt, e.cyc, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        btn_in = 1'b1;
        repeat (5) @(negedge clk);  // now in PRESS_DB with dcnt=2
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
        rstn   = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy: got %b expected 0", busy); end
        compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL mid_level: got %b expected 0", level); end
        compared++; if (press_count !== 8'd0) begin mismatched++; $display("FAIL mid_count: got %0d expected 0", press_count); end
        rstn = 1'b0;
        exp_cnt = 8'd0;
        repeat (20) @(negedge clk);
        compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL mid_npulse: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        int k;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            btn_in = 1'b1;
            k = cyc;
            exp_cnt++;
            exp_q.push_back(mk(k + LAT, exp_cnt));
            repeat (8) @(negedge clk);
            btn_in = 1'b0;
            repeat (8) @(negedge clk);
        end
        compared++; if (obs_q.size() != 256) begin mismatched++; $display("FAIL wrap_npulse: got %0d expected 256", obs_q.size()); end
        compared++; if (press_count !== 8'd0) begin mismatched++; $display("FAIL wrap_count: got %0d expected 0", press_count); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            compared++; if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin mismatched++; $display("FAIL wrap_pulse_ev: got cyc %0d cnt %0d expected cyc %0d cnt %0d", o.cyc, o.cnt, e.cyc, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        btn_in = 1'b0;
        rstn   = 1'b1;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
